// File: rtl/fetch_imem_cache_if.sv
// Fetch-side and backing-bus signals of the instruction cache.
// The cache uses modport slave; the fetch stage / memory model uses modport master.
interface fetch_imem_cache_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      pc_rom;
    logic             inv;
    logic [31:0]      inst_rom;
    logic             stall;
    logic             addr_err;
    logic             bus_req;
    logic [31:0]      bus_addr;
    logic             bus_gnt;
    logic             bus_rvalid;
    logic [31:0]      bus_rdata;
    logic [CNT_W-1:0] miss_cnt;

    modport slave (
        input  pc_rom, inv, bus_gnt, bus_rvalid, bus_rdata,
        output inst_rom, stall, addr_err, bus_req, bus_addr, miss_cnt
    );

    modport master (
        output pc_rom, inv, bus_gnt, bus_rvalid, bus_rdata,
        input  inst_rom, stall, addr_err, bus_req, bus_addr, miss_cnt
    );
endinterface

// File: rtl/fetch_imem_cache.sv
// Direct-mapped, one-word-per-line instruction cache. Hits answer in the same cycle;
// misses stall IF and refill the line over a req/gnt + rvalid read.
module fetch_imem_cache #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    fetch_imem_cache_if.slave  io
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t             state_q;
    logic [DEPTH-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [DEPTH];
    logic [31:0]        data_q [DEPTH];
    logic [31:2]        miss_addr_q;
    logic               bus_req_q;
    logic [31:0]        bus_addr_q;
    logic [CNT_W-1:0]   miss_cnt_q;

    logic               aligned_s;
    logic               hit_s;
    logic               miss_s;
    logic [IDX_W-1:0]   idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic [IDX_W-1:0]   miss_idx_s;
    logic [31:2]        miss_addr_d;
    logic [CNT_W-1:0]   miss_cnt_d;
    logic               fill_s;

    // Address decode, hit detection and the combinational fetch-side answer.
    always_comb begin
        aligned_s   = (io.pc_rom[1:0] == 2'b00);
        idx_s       = io.pc_rom[IDX_W+1:2];
        tag_s       = io.pc_rom[31:IDX_W+2];
        hit_s       = aligned_s && (state_q == IDLE) && valid_q[idx_s] && (tag_q[idx_s] == tag_s);
        miss_s      = aligned_s && !hit_s;
        miss_idx_s  = miss_addr_q[IDX_W+1:2];
        miss_addr_d = io.pc_rom[31:2];
        fill_s      = (state_q == WAIT) && io.bus_rvalid;
        if (miss_cnt_q == {CNT_W{1'b1}}) begin
            miss_cnt_d = miss_cnt_q;
        end else begin
            miss_cnt_d = miss_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (hit_s) begin
            io.inst_rom = data_q[idx_s];
        end else begin
            io.inst_rom = 32'h0000_0000;
        end
        io.stall    = miss_s;
        io.addr_err = !aligned_s;
    end

    assign io.bus_req  = bus_req_q;
    assign io.bus_addr = bus_addr_q;
    assign io.miss_cnt = miss_cnt_q;

    // Refill FSM with registered bus outputs, valid bits and miss counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            valid_q     <= {DEPTH{1'b0}};
            miss_addr_q <= 30'd0;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            miss_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_s) begin
                        miss_addr_q <= miss_addr_d;
                        bus_addr_q  <= {miss_addr_d, 2'b00};
                        bus_req_q   <= 1'b1;
                        miss_cnt_q  <= miss_cnt_d;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (io.bus_gnt) begin
                        bus_req_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (io.bus_rvalid) begin
                        valid_q[miss_idx_s] <= 1'b1;
                        state_q             <= IDLE;
                    end
                end
                default: begin
                    bus_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
            // Invalidate overrides a same-cycle fill: the data lands but stays invalid.
            if (io.inv) begin
                valid_q <= {DEPTH{1'b0}};
            end
        end
    end

    // Line storage; contents are meaningless until the matching valid bit is set.
    always_ff @(posedge clk_i) begin
        if (fill_s) begin
            data_q[miss_idx_s] <= io.bus_rdata;
            tag_q[miss_idx_s]  <= miss_addr_q[31:IDX_W+2];
        end
    end
endmodule

// File: tb/tb_fetch_imem_cache.sv
// Directed bench for fetch_imem_cache: cold miss, hits, conflict, misaligned fetch,
// invalidate racing a fill, and reset in the middle of a refill.
module tb_fetch_imem_cache;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    fetch_imem_cache_if #(.CNT_W(16)) bus_if ();

    fetch_imem_cache #(.DEPTH(8), .CNT_W(16)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .io     (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Best-case refill: miss in c0, gnt in c1, rvalid in c2, hit in c3.
    task automatic fill(input logic [31:0] pc, input logic [31:0] d, input logic [15:0] cnt);
        bus_if.pc_rom = pc;
        @(negedge clk);
        chk("fill_stall_c0", {31'd0, bus_if.stall}, 32'd1);
        next_cycle();
        bus_if.bus_gnt = 1'b1;
        @(negedge clk);
        chk("fill_req_c1", {31'd0, bus_if.bus_req}, 32'd1);
        chk("fill_addr_c1", bus_if.bus_addr, pc);
        chk("fill_cnt_c1", {16'd0, bus_if.miss_cnt}, {16'd0, cnt});
        next_cycle();
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = d;
        @(negedge clk);
        chk("fill_req_c2", {31'd0, bus_if.bus_req}, 32'd0);
        chk("fill_stall_c2", {31'd0, bus_if.stall}, 32'd1);
        next_cycle();
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("fill_stall_c3", {31'd0, bus_if.stall}, 32'd0);
        chk("fill_inst_c3", bus_if.inst_rom, d);
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst_n             = 1'b0;
        bus_if.pc_rom     = 32'h0;
        bus_if.inv        = 1'b0;
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = 32'h0;

        // Reset state
        @(negedge clk);
        chk("rst_req", {31'd0, bus_if.bus_req}, 32'd0);
        chk("rst_addr", bus_if.bus_addr, 32'h0);
        chk("rst_cnt", {16'd0, bus_if.miss_cnt}, 32'd0);
        chk("rst_inst", bus_if.inst_rom, 32'h0);
        next_cycle();
        rst_n = 1'b1;

        // T1 cold miss: gnt in c2, rvalid in c4, hit in c5
        bus_if.pc_rom = 32'h0;
        @(negedge clk);
        chk("t1_stall_c0", {31'd0, bus_if.stall}, 32'd1);
        chk("t1_inst_c0", bus_if.inst_rom, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("t1_req_c1", {31'd0, bus_if.bus_req}, 32'd1);
        chk("t1_addr_c1", bus_if.bus_addr, 32'h0);
        chk("t1_stall_c1", {31'd0, bus_if.stall}, 32'd1);
        chk("t1_cnt_c1", {16'd0, bus_if.miss_cnt}, 32'd1);
        next_cycle();
        bus_if.bus_gnt = 1'b1;
        @(negedge clk);
        chk("t1_req_c2", {31'd0, bus_if.bus_req}, 32'd1);
        next_cycle();
        bus_if.bus_gnt = 1'b0;
        @(negedge clk);
        chk("t1_req_c3", {31'd0, bus_if.bus_req}, 32'd0);
        chk("t1_stall_c3", {31'd0, bus_if.stall}, 32'd1);
        next_cycle();
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 32'h2402_000A;
        @(negedge clk);
        chk("t1_stall_c4", {31'd0, bus_if.stall}, 32'd1);
        next_cycle();
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = 32'h0;
        @(negedge clk);
        chk("t1_stall_c5", {31'd0, bus_if.stall}, 32'd0);
        chk("t1_inst_c5", bus_if.inst_rom, 32'h2402_000A);

        // T2 hits on two filled lines, no bus traffic
        next_cycle();
        fill(32'h4, 32'h8C43_0004, 16'd2);
        next_cycle();
        bus_if.pc_rom = 32'h0;
        @(negedge clk);
        chk("t2_inst0", bus_if.inst_rom, 32'h2402_000A);
        chk("t2_stall0", {31'd0, bus_if.stall}, 32'd0);
        next_cycle();
        bus_if.pc_rom = 32'h4;
        @(negedge clk);
        chk("t2_inst4", bus_if.inst_rom, 32'h8C43_0004);
        chk("t2_req", {31'd0, bus_if.bus_req}, 32'd0);
        chk("t2_cnt", {16'd0, bus_if.miss_cnt}, 32'd2);

        // T3 conflict: 0x20 evicts index 0, then 0x0 refills it
        next_cycle();
        fill(32'h20, 32'h1111_1111, 16'd3);
        next_cycle();
        fill(32'h0, 32'h2222_2222, 16'd4);
        chk("t3_cnt", {16'd0, bus_if.miss_cnt}, 32'd4);

        // T4 misaligned fetch: no stall, no data, no bus request
        next_cycle();
        bus_if.pc_rom = 32'h6;
        @(negedge clk);
        chk("t4_err", {31'd0, bus_if.addr_err}, 32'd1);
        chk("t4_stall", {31'd0, bus_if.stall}, 32'd0);
        chk("t4_inst", bus_if.inst_rom, 32'h0);
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            @(negedge clk);
            chk("t4_noreq", {31'd0, bus_if.bus_req}, 32'd0);
        end
        chk("t4_cnt", {16'd0, bus_if.miss_cnt}, 32'd4);

        // T5 inv in the rvalid cycle: line stays invalid, same address re-requested
        next_cycle();
        bus_if.pc_rom = 32'h40;
        @(negedge clk);
        chk("t5_stall_c0", {31'd0, bus_if.stall}, 32'd1);
        next_cycle();
        bus_if.bus_gnt = 1'b1;
        next_cycle();
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 32'h3333_3333;
        bus_if.inv        = 1'b1;
        next_cycle();
        bus_if.bus_rvalid = 1'b0;
        bus_if.inv        = 1'b0;
        @(negedge clk);
        chk("t5_stall_c3", {31'd0, bus_if.stall}, 32'd1);
        chk("t5_inst_c3", bus_if.inst_rom, 32'h0);
        next_cycle();
        bus_if.bus_gnt = 1'b1;
        @(negedge clk);
        chk("t5_req_c4", {31'd0, bus_if.bus_req}, 32'd1);
        chk("t5_addr_c4", bus_if.bus_addr, 32'h40);
        chk("t5_cnt_c4", {16'd0, bus_if.miss_cnt}, 32'd6);
        next_cycle();
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 32'h4444_4444;
        next_cycle();
        bus_if.bus_rvalid = 1'b0;
        @(negedge clk);
        chk("t5_hit", bus_if.inst_rom, 32'h4444_4444);
        chk("t5_stall_hit", {31'd0, bus_if.stall}, 32'd0);

        // T6 reset after gnt: bus_req drops at once, stray rvalid ignored
        next_cycle();
        bus_if.pc_rom = 32'h4;
        @(negedge clk);
        chk("t6_stall_c0", {31'd0, bus_if.stall}, 32'd1);
        next_cycle();
        bus_if.bus_gnt = 1'b1;
        next_cycle();
        bus_if.bus_gnt = 1'b0;
        rst_n          = 1'b0;
        #1;
        chk("t6_req_async", {31'd0, bus_if.bus_req}, 32'd0);
        chk("t6_cnt_rst", {16'd0, bus_if.miss_cnt}, 32'd0);
        next_cycle();
        rst_n             = 1'b1;
        bus_if.pc_rom     = 32'h0;
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 32'h5555_5555;
        @(negedge clk);
        chk("t6_stall", {31'd0, bus_if.stall}, 32'd1);
        chk("t6_inst", bus_if.inst_rom, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("t6_req", {31'd0, bus_if.bus_req}, 32'd1);
        chk("t6_addr", bus_if.bus_addr, 32'h0);
        chk("t6_cnt", {16'd0, bus_if.miss_cnt}, 32'd1);
        next_cycle();
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_gnt    = 1'b1;
        next_cycle();
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 32'h6666_6666;
        next_cycle();
        bus_if.bus_rvalid = 1'b0;
        @(negedge clk);
        chk("t6_hit", bus_if.inst_rom, 32'h6666_6666);
        chk("t6_stall_hit", {31'd0, bus_if.stall}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
